tff_bank_arbiter: RTL and testbench

- Shares a bank of `NBITS` toggle flip-flops between `NREQ` requesters.
- Each requester issues toggle, clear, set or read operations on one selected bit through a req/gnt/ack handshake.
- A round-robin arbiter serialises the operations, and a small state machine applies them.
- Sits between the control agents and the shared flag/toggle register file; the bank state is exported continuously as `q` and `qb`.

---
 rtl/tff_pkg.sv | 35 +++
 rtl/tff_cell.sv | 33 +++
 rtl/tff_bank_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_tff_bank_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared types and op helpers for the toggle flip-flop bank arbiter.
package tff_pkg;

  typedef enum logic [1:0] {
    TOGGLE = 2'b00,
    CLEAR  = 2'b01,
    SET    = 2'b10,
    READ   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ACK  = 2'b10
  } state_t;

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  // Value a bit holds after the op is applied to its current value.
  function automatic logic apply_op(input op_t op, input logic cur);
    logic nxt;
    case (op)
      TOGGLE:  nxt = ~cur;
      CLEAR:   nxt = 1'b0;
      SET:     nxt = 1'b1;
      READ:    nxt = cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One T flip-flop of the bank with clear/set strobes.
// Priority: reset > clr > set > t.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic clr,
  input  logic set,
  output logic q,
  output logic qb
);

  logic q_r;

  // Bit state register; a toggle inverts the held value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 1'b0;
    end else if (clr) begin
      q_r <= 1'b0;
    end else if (set) begin
      q_r <= 1'b1;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q  = q_r;
  assign qb = ~q_r;

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing a bank of T flip-flops between NREQ requesters.
// One op per three cycles: IDLE (grant) -> EXEC (apply, ack) -> ACK (release).
module tff_bank_arbiter
  import tff_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = $clog2(NBITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [IDXW*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   rdata,
  output logic                   err,
  output logic                   busy,
  output logic [NBITS-1:0]       q,
  output logic [NBITS-1:0]       qb
);

  localparam int RIDW = $clog2(NREQ);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [RIDW-1:0]   rr_ptr_r;
  logic [RIDW-1:0]   rr_nxt_s;
  logic [RIDW-1:0]   win_r;
  logic [1:0]        op_r;
  logic [IDXW-1:0]   idx_r;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   ack_r;
  logic              rdata_r;
  logic              err_r;
  logic              busy_r;

  logic              win_found_s;
  logic [RIDW-1:0]   win_id_s;
  logic [RIDW-1:0]   cand_s;
  logic [1:0]        sel_op_s;
  logic [IDXW-1:0]   sel_idx_s;
  logic              ld_s;
  logic [NREQ-1:0]   gnt_nxt_s;
  logic [NREQ-1:0]   ack_nxt_s;
  logic              rdata_nxt_s;
  logic              err_nxt_s;

  logic              idx_ok_s;
  logic              cur_bit_s;
  logic [NBITS-1:0]  t_s;
  logic [NBITS-1:0]  clr_s;
  logic [NBITS-1:0]  set_s;
  logic [NBITS-1:0]  q_s;
  logic [NBITS-1:0]  qb_s;

  // Round-robin pick: first active request at or after rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = RIDW'((int'(rr_ptr_r) + k) % NREQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the winner's op and index slices.
  always_comb begin
    sel_op_s  = 2'b00;
    sel_idx_s = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (win_id_s == RIDW'(r)) begin
        sel_op_s  = req_op[2*r +: 2];
        sel_idx_s = req_idx[IDXW*r +: IDXW];
      end else begin
        sel_op_s  = sel_op_s;
      end
    end
  end

  assign idx_ok_s = ({1'b0, idx_r} < (IDXW+1)'(NBITS));

  // Decode the latched op into a single one-cycle strobe on the target cell.
  always_comb begin
    t_s       = '0;
    clr_s     = '0;
    set_s     = '0;
    cur_bit_s = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      if (idx_r == IDXW'(i)) begin
        cur_bit_s = q_s[i];
        if (state_r == EXEC) begin
          t_s[i]   = (op_r == OP_TOGGLE);
          clr_s[i] = (op_r == OP_CLEAR);
          set_s[i] = (op_r == OP_SET);
        end else begin
          t_s[i]   = 1'b0;
        end
      end else begin
        t_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NBITS; g++) begin : g_bank
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t_s[g]),
      .clr   (clr_s[g]),
      .set   (set_s[g]),
      .q     (q_s[g]),
      .qb    (qb_s[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC:    state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next values for the registered handshake and result.
  always_comb begin
    gnt_nxt_s   = gnt_r;
    ack_nxt_s   = '0;
    rdata_nxt_s = rdata_r;
    err_nxt_s   = err_r;
    rr_nxt_s    = rr_ptr_r;
    ld_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          gnt_nxt_s = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
          ld_s      = 1'b1;
        end else begin
          gnt_nxt_s = '0;
        end
      end
      EXEC: begin
        ack_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_r;
        rdata_nxt_s = idx_ok_s ? apply_op(op_t'(op_r), cur_bit_s) : 1'b0;
        err_nxt_s   = ~idx_ok_s;
        rr_nxt_s    = (win_r == RIDW'(NREQ-1)) ? RIDW'(0) : win_r + RIDW'(1);
      end
      ACK: begin
        gnt_nxt_s = '0;
        ack_nxt_s = '0;
      end
      default: begin
        gnt_nxt_s = '0;
        ack_nxt_s = '0;
      end
    endcase
  end

  // Handshake, result and transaction-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r    <= '0;
      ack_r    <= '0;
      rdata_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      rr_ptr_r <= '0;
      win_r    <= '0;
      op_r     <= 2'b00;
      idx_r    <= '0;
    end else begin
      gnt_r    <= gnt_nxt_s;
      ack_r    <= ack_nxt_s;
      rdata_r  <= rdata_nxt_s;
      err_r    <= err_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      rr_ptr_r <= rr_nxt_s;
      if (ld_s) begin
        win_r <= win_id_s;
        op_r  <= sel_op_s;
        idx_r <= sel_idx_s;
      end else begin
        win_r <= win_r;
        op_r  <= op_r;
        idx_r <= idx_r;
      end
    end
  end

  assign gnt   = gnt_r;
  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign err   = err_r;
  assign busy  = busy_r;
  assign q     = q_s;
  assign qb    = qb_s;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Self-checking bench for tff_bank_arbiter: vector table, scoreboard and
// hand-written multi-cycle sequences.
module tb_tff_bank_arbiter;
  import tff_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [11:0] req_idx;
  logic [3:0]  gnt, ack;
  logic        rdata, err, busy;
  logic [7:0]  q, qb;

  logic [3:0]  req6;
  logic [7:0]  req_op6;
  logic [11:0] req_idx6;
  logic [3:0]  gnt6, ack6;
  logic        rdata6, err6, busy6;
  logic [5:0]  q6, qb6;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         rid;
    logic       rdata;
    logic       err;
    logic [7:0] q;
  } exp_t;

  typedef struct {
    int         rid;
    logic [1:0] op;
    int         idx;
    logic       exp_rdata;
    logic [7:0] exp_q;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[12];

  tff_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_idx(req_idx),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy), .q(q), .qb(qb)
  );

  tff_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .req_op(req_op6), .req_idx(req_idx6),
    .gnt(gnt6), .ack(ack6), .rdata(rdata6), .err(err6), .busy(busy6), .q(q6), .qb(qb6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int rid, input logic [1:0] op, input int idx);
    req_op[2*rid +: 2]  = op;
    req_idx[3*rid +: 3] = 3'(idx);
    req[rid]            = 1'b1;
  endtask

  task automatic push_exp(input int rid, input logic rd, input logic e, input logic [7:0] qq);
    exp_t x;
    x.rid = rid; x.rdata = rd; x.err = e; x.q = qq;
    sb_q.push_back(x);
  endtask

  task automatic wait_any_ack(input logic [3:0] mask, output int w, output bit seen);
    seen = 1'b0;
    w = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if ((ack & mask) != 4'b0000) begin
        seen = 1'b1;
        for (int i = 0; i < 4; i++) if (ack[i]) w = i;
        break;
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: got no ack in mask 0x%0h, required one", mask);
    end
  endtask

  task automatic run6(input logic [1:0] op, input int idx, input logic rd, input logic e,
                      input logic [5:0] qq);
    bit seen;
    logic [5:0] qbx;
    seen = 1'b0;
    qbx = ~qq;
    req_op6[1:0]  = op;
    req_idx6[2:0] = 3'(idx);
    req6[0]       = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge clk); #1;
      if (ack6[0]) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL oor_ack_timeout: got no ack, required ack idx=%0d", idx);
    end else begin
      check("oor_rdata", 32'(rdata6), 32'(rd));
      check("oor_err", 32'(err6), 32'(e));
      check("oor_q", 32'(q6), 32'(qq));
      check("oor_qb", 32'(qb6), 32'(qbx));
    end
    req6[0] = 1'b0;
    @(posedge clk); #1;
    check("oor_release", 32'({busy6, ack6, gnt6}), 32'h0);
  endtask

  // Scoreboard: every ack is matched against the oldest expected completion.
  always @(posedge clk) begin
    logic [7:0] qbx;
    #1;
    if (ack !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack: got 0x%0h, required none", ack);
      end else begin
        sb_e = sb_q.pop_front();
        qbx = ~sb_e.q;
        check("sb_ack", 32'(ack), 32'(4'b0001 << sb_e.rid));
        check("sb_rdata", 32'(rdata), 32'(sb_e.rdata));
        check("sb_err", 32'(err), 32'(sb_e.err));
        check("sb_q", 32'(q), 32'(sb_e.q));
        check("sb_qb", 32'(qb), 32'(qbx));
      end
    end
  end

  initial begin
    bit seen;
    int w;
    int last;
    req = '0; req_op = '0; req_idx = '0;
    req6 = '0; req_op6 = '0; req_idx6 = '0;
    last = 0;

    vecs[0]  = '{2, OP_TOGGLE, 5, 1'b1, 8'h28};
    vecs[1]  = '{2, OP_TOGGLE, 5, 1'b0, 8'h08};
    vecs[2]  = '{2, OP_CLEAR,  5, 1'b0, 8'h08};
    vecs[3]  = '{2, OP_READ,   5, 1'b0, 8'h08};
    vecs[4]  = '{1, OP_SET,    7, 1'b1, 8'h88};
    vecs[5]  = '{3, OP_CLEAR,  3, 1'b0, 8'h80};
    vecs[6]  = '{0, OP_READ,   7, 1'b1, 8'h80};
    vecs[7]  = '{2, OP_TOGGLE, 0, 1'b1, 8'h81};
    vecs[8]  = '{1, OP_READ,   0, 1'b1, 8'h81};
    vecs[9]  = '{3, OP_TOGGLE, 7, 1'b0, 8'h01};
    vecs[10] = '{0, OP_SET,    0, 1'b1, 8'h01};
    vecs[11] = '{3, OP_CLEAR,  6, 1'b0, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_q", 32'(q), 32'h00);
    check("rst_qb", 32'(qb), 32'hff);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rdata_err_busy", 32'({rdata, err, busy}), 32'h0);
    check("rst_qb6", 32'(qb6), 32'h3f);

    // Single toggle, cycle by cycle.
    set_req(0, OP_TOGGLE, 3);
    push_exp(0, 1'b1, 1'b0, 8'h08);
    @(posedge clk); #1;
    check("t1_gnt_e0", 32'(gnt), 32'h1);
    check("t1_busy_e0", 32'(busy), 32'h1);
    check("t1_ack_e0", 32'(ack), 32'h0);
    check("t1_q_e0", 32'(q), 32'h00);
    @(posedge clk); #1;
    check("t1_ack_e1", 32'(ack), 32'h1);
    check("t1_gnt_e1", 32'(gnt), 32'h1);
    check("t1_q_e1", 32'(q), 32'h08);
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_release_e2", 32'({busy, ack, gnt}), 32'h0);

    for (int v = 0; v < 12; v++) begin
      set_req(vecs[v].rid, vecs[v].op, vecs[v].idx);
      push_exp(vecs[v].rid, vecs[v].exp_rdata, 1'b0, vecs[v].exp_q);
      wait_any_ack(4'b0001 << vecs[v].rid, w, seen);
      req = '0;
      @(posedge clk); #1;
    end

    // Four simultaneous SETs after reset: grant order 0..3, acks 3 cycles apart.
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(i, OP_SET, i);
      push_exp(i, 1'b1, 1'b0, 8'((1 << (i + 1)) - 1));
    end
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(4'b1111, w, seen);
      if (!seen) break;
      req[w] = 1'b0;
      if (k > 0) check("t2_ack_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    req = '0;
    @(posedge clk); #1;
    check("t2_q", 32'(q), 32'h0f);

    // req1 and req3 held continuously: service alternates 1,3,1,3.
    set_req(1, OP_TOGGLE, 4);
    set_req(3, OP_READ, 4);
    push_exp(1, 1'b1, 1'b0, 8'h1f);
    push_exp(3, 1'b1, 1'b0, 8'h1f);
    push_exp(1, 1'b0, 1'b0, 8'h0f);
    push_exp(3, 1'b0, 1'b0, 8'h0f);
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(4'b1010, w, seen);
      if (!seen) break;
      if (k == 3) begin
        req = '0;
      end else begin
        req[w] = 1'b0;
        @(posedge clk); #1;
        req[w] = 1'b1;
      end
    end
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_idle", 32'({busy, gnt}), 32'h0);
    check("t3_q", 32'(q), 32'h0f);

    // Reset during EXEC aborts the SET and clears the bank.
    set_req(0, OP_SET, 2);
    @(posedge clk); #1;
    check("t6_gnt", 32'(gnt), 32'h1);
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_no_ack", 32'(ack), 32'h0);
    check("t6_q", 32'(q), 32'h00);
    check("t6_qb", 32'(qb), 32'hff);
    check("t6_idle", 32'({busy, gnt}), 32'h0);
    @(posedge clk); #1;
    check("t6_still_idle", 32'({busy, ack, gnt}), 32'h0);
    set_req(0, OP_SET, 2);
    push_exp(0, 1'b1, 1'b0, 8'h04);
    wait_any_ack(4'b0001, w, seen);
    req = '0;
    @(posedge clk); #1;
    check("t6_fresh_q", 32'(q), 32'h04);

    // Out-of-range indices on the 6-bit bank.
    run6(OP_SET,    1, 1'b1, 1'b0, 6'h02);
    run6(OP_TOGGLE, 7, 1'b0, 1'b1, 6'h02);
    run6(OP_SET,    6, 1'b0, 1'b1, 6'h02);
    run6(OP_READ,   5, 1'b0, 1'b0, 6'h02);
    run6(OP_TOGGLE, 5, 1'b1, 1'b0, 6'h22);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
